// File: rtl/caxi4interconnect_arb_pkg.sv
// Shared helpers for the interconnect arbiters: the one-hot to binary encoder
// and the per-requestor weight slice extractor, plus the arbitration action enum.
package caxi4interconnect_arb_pkg;

    localparam int unsigned ARB_MAX_REQ     = 32;
    localparam int unsigned ARB_MAX_W_WIDTH = 8;

    // What the arbiter does with the grant in a given cycle.
    typedef enum logic [2:0] {
        ARB_HOLD,     // no evaluation, or evaluation suppressed by a lock
        ARB_REPEAT,   // holder keeps the grant and spends one credit
        ARB_ROTATE,   // a new winner is picked from the request vector
        ARB_REGRANT,  // nobody else wants the bus, holder is granted afresh
        ARB_IDLE      // nothing to grant
    } arb_action_e;

    // Binary index of the set bit in a one-hot (or zero) vector.
    function automatic logic [4:0] onehot_to_bin(input logic [ARB_MAX_REQ-1:0] onehot);
        logic [4:0] bin;
        bin = '0;
        for (int i = 0; i < int'(ARB_MAX_REQ); i++) begin
            if (onehot[i]) begin
                bin = bin | 5'(i);
            end
        end
        return bin;
    endfunction

    // Weight of requestor idx from a flattened weight vector of w_width-bit lanes.
    function automatic logic [ARB_MAX_W_WIDTH-1:0] weight_slice(
        input logic [ARB_MAX_REQ*ARB_MAX_W_WIDTH-1:0] weights,
        input int unsigned                            idx,
        input int unsigned                            w_width
    );
        logic [ARB_MAX_REQ*ARB_MAX_W_WIDTH-1:0] shifted;
        logic [ARB_MAX_W_WIDTH-1:0]             lane_mask;
        shifted   = weights >> (idx * w_width);
        lane_mask = 8'((9'd1 << w_width) - 9'd1);
        return shifted[ARB_MAX_W_WIDTH-1:0] & lane_mask;
    endfunction

endpackage

// File: rtl/caxi4interconnect_rr_pick.sv
// Round-robin priority pick: lowest-index request inside the priority mask,
// falling back to the lowest-index request overall when the mask hides them all.
module caxi4interconnect_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] request_i,
    input  logic [N-1:0] mask_i,
    output logic [N-1:0] pick_o,
    output logic         any_masked_o
);

    logic [N-1:0] masked_req;
    logic [N-1:0] sel_req;

    // Choose masked or unmasked requests, then isolate the lowest set bit.
    always_comb begin
        masked_req   = request_i & mask_i;
        any_masked_o = |masked_req;
        sel_req      = any_masked_o ? masked_req : request_i;
        pick_o       = sel_req & (~sel_req + N'(1));
    end

endmodule

// File: rtl/caxi4interconnect_weighted_rr_arb.sv
// Weighted round-robin arbiter with registered one-hot and binary grant.
// A winner with weight w keeps the bus for w+1 consecutive arbitration slots
// while it keeps requesting. Optional feature: define ARB_LOCK_EN to let the
// holder pin the grant with lockReq (no credit spent while locked).
module caxi4interconnect_weighted_rr_arb
    import caxi4interconnect_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int N_WIDTH = 2,
    parameter int W_WIDTH = 2
) (
    input  logic                 sysClk,
    input  logic                 sysReset,
    input  logic [N-1:0]         requestor,
    input  logic [N*W_WIDTH-1:0] weight,
    input  logic                 arbEnable,
    input  logic                 lockReq,
    output logic [N-1:0]         grant,
    output logic [N_WIDTH-1:0]   grantEnc,
    output logic                 grantValid
);

    logic [N-1:0]       grant_q,       grant_d;
    logic [N_WIDTH-1:0] grant_enc_q,   grant_enc_d;
    logic               grant_valid_q, grant_valid_d;
    logic [W_WIDTH-1:0] credit_q,      credit_d;
    logic [N-1:0]       mask_q,        mask_d;

    logic [N-1:0]       candidates;
    logic [N-1:0]       pick;
    logic               unused_any_masked;
    logic               holder_req;
    logic               lock_hold;
    arb_action_e        action;
    logic [N-1:0]       win_oh;
    logic [ARB_MAX_REQ-1:0]                 win_oh_ext;
    logic [ARB_MAX_REQ*ARB_MAX_W_WIDTH-1:0] weight_ext;

`ifdef ARB_LOCK_EN
    assign lock_hold = lockReq;
`else
    logic unused_lock_req;
    assign unused_lock_req = lockReq;
    assign lock_hold       = 1'b0;
`endif

    // Requestors strictly above a one-hot winner form the next priority window.
    function automatic logic [N-1:0] bits_above(input logic [N-1:0] onehot);
        return ~((onehot << 1) - N'(1));
    endfunction

    // While a grant is live the holder is never a rotation candidate.
    assign candidates = grant_valid_q ? (requestor & ~grant_q) : requestor;
    assign holder_req = |(requestor & grant_q);

    caxi4interconnect_rr_pick #(.N(N)) u_pick (
        .request_i    (candidates),
        .mask_i       (mask_q),
        .pick_o       (pick),
        .any_masked_o (unused_any_masked)
    );

    // Decide this cycle's action and form the next grant, credit and mask.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can leave one unassigned and infer a latch.
        grant_d       = grant_q;
        grant_enc_d   = grant_enc_q;
        grant_valid_d = grant_valid_q;
        credit_d      = credit_q;
        mask_d        = mask_q;
        win_oh        = '0;
        win_oh_ext    = '0;
        weight_ext    = '0;
        weight_ext[N*W_WIDTH-1:0] = weight;
        action        = ARB_HOLD;

        if (!grant_valid_q) begin
            action = (|requestor) ? ARB_ROTATE : ARB_IDLE;
        end else if (arbEnable) begin
            if (lock_hold) begin
                action = ARB_HOLD;
            end else if ((credit_q != '0) && holder_req) begin
                action = ARB_REPEAT;
            end else if (|candidates) begin
                action = ARB_ROTATE;
            end else if (holder_req) begin
                action = ARB_REGRANT;
            end else begin
                action = ARB_IDLE;
            end
        end

        case (action)
            ARB_ROTATE:  win_oh = pick;
            ARB_REGRANT: win_oh = grant_q;
            default:     win_oh = '0;
        endcase
        win_oh_ext[N-1:0] = win_oh;

        case (action)
            ARB_REPEAT: begin
                credit_d = credit_q - W_WIDTH'(1);
            end
            ARB_ROTATE, ARB_REGRANT: begin
                grant_d       = win_oh;
                grant_enc_d   = N_WIDTH'(onehot_to_bin(win_oh_ext));
                grant_valid_d = 1'b1;
                credit_d      = W_WIDTH'(weight_slice(weight_ext,
                                    32'(onehot_to_bin(win_oh_ext)), W_WIDTH));
                mask_d        = bits_above(win_oh);
            end
            ARB_IDLE: begin
                grant_d       = '0;
                grant_enc_d   = '0;
                grant_valid_d = 1'b0;
                credit_d      = '0;
            end
            default: begin
            end
        endcase
    end

    // Grant state registers; reset abandons any grant and restores requestor 0 priority.
    always_ff @(posedge sysClk or negedge sysReset) begin
        if (!sysReset) begin
            grant_q       <= '0;
            grant_enc_q   <= '0;
            grant_valid_q <= 1'b0;
            credit_q      <= '0;
            mask_q        <= '1;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            grant_q       <= grant_d;
            grant_enc_q   <= grant_enc_d;
            grant_valid_q <= grant_valid_d;
            credit_q      <= credit_d;
            mask_q        <= mask_d;
        end
    end

    assign grant      = grant_q;
    assign grantEnc   = grant_enc_q;
    assign grantValid = grant_valid_q;

endmodule

// File: tb/tb_caxi4interconnect_weighted_rr_arb.sv
// Self-checking bench for caxi4interconnect_weighted_rr_arb (N=4, W_WIDTH=2):
// directed scenarios plus randomized traffic against a behavioural model that
// tracks the holder index, remaining repeat count and last rotation winner.
module tb_caxi4interconnect_weighted_rr_arb;

    localparam int N       = 4;
    localparam int N_WIDTH = 2;
    localparam int W_WIDTH = 2;

    logic                 sysClk = 1'b0;
    logic                 sysReset;
    logic [N-1:0]         requestor;
    logic [N*W_WIDTH-1:0] weight;
    logic                 arbEnable;
    logic                 lockReq;
    logic [N-1:0]         grant;
    logic [N_WIDTH-1:0]   grantEnc;
    logic                 grantValid;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    bit m_valid;
    int m_holder;
    int m_credit;
    int m_last;
    int m_w[N];

    caxi4interconnect_weighted_rr_arb #(.N(N), .N_WIDTH(N_WIDTH), .W_WIDTH(W_WIDTH)) dut (
        .sysClk     (sysClk),
        .sysReset   (sysReset),
        .requestor  (requestor),
        .weight     (weight),
        .arbEnable  (arbEnable),
        .lockReq    (lockReq),
        .grant      (grant),
        .grantEnc   (grantEnc),
        .grantValid (grantValid)
    );

    always #5 sysClk = ~sysClk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic set_weights(input int w0, input int w1, input int w2, input int w3);
        m_w[0] = w0; m_w[1] = w1; m_w[2] = w2; m_w[3] = w3;
        weight = {2'(w3), 2'(w2), 2'(w1), 2'(w0)};
    endtask

    task automatic model_reset();
        m_valid  = 0;
        m_holder = 0;
        m_credit = 0;
        m_last   = -1;
    endtask

    // One arbitration slot of the reference behaviour.
    task automatic model_step(input logic [N-1:0] req, input bit arb, input bit lk);
        bit holder_req;
        int winner;
        int idx;
        if (m_valid && !arb) return;
        holder_req = m_valid && req[m_holder];
`ifdef ARB_LOCK_EN
        if (m_valid && lk) return;
`else
        if (lk && 0) return;
`endif
        if (m_valid && m_credit > 0 && holder_req) begin
            m_credit--;
            return;
        end
        winner = -1;
        for (int k = 1; k <= N; k++) begin
            idx = (m_last + k) % N;
            if (winner < 0 && req[idx] && !(m_valid && idx == m_holder)) winner = idx;
        end
        if (winner >= 0) begin
            m_valid = 1; m_holder = winner; m_credit = m_w[winner]; m_last = winner;
        end else if (holder_req) begin
            m_credit = m_w[m_holder]; m_last = m_holder;
        end else begin
            m_valid = 0;
        end
    endtask

    task automatic compare_model();
        check("grant", 32'(grant), m_valid ? (32'd1 << m_holder) : 32'd0);
        check("grantEnc", 32'(grantEnc), m_valid ? 32'(m_holder) : 32'd0);
        check("grantValid", 32'(grantValid), 32'(m_valid));
        check("onehot0", 32'($onehot0(grant)), 32'd1);
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check just after it.
    task automatic cycle(input logic [N-1:0] req, input logic arb, input logic lk);
        requestor = req;
        arbEnable = arb;
        lockReq   = lk;
        @(posedge sysClk);
        model_step(req, arb, lk);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        sysReset  = 1'b0;
        requestor = '0;
        arbEnable = 1'b0;
        lockReq   = 1'b0;
        model_reset();
        repeat (2) @(posedge sysClk);
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_enc", 32'(grantEnc), 32'd0);
        check("rst_valid", 32'(grantValid), 32'd0);
        sysReset = 1'b1;
    endtask

    logic [N-1:0] seq031 [8];

    initial begin
        sysReset = 1'b0;
        set_weights(0, 0, 0, 0);

        // Reset, single requestor 0 is granted one cycle later.
        do_reset();
        cycle(4'b0001, 1'b0, 1'b0);
        check("r030_grant", 32'(grant), 32'h1);
        check("r030_valid", 32'(grantValid), 32'h1);

        // Weight 2 on requestor 0 yields three grants before requestor 1 gets one.
        set_weights(2, 0, 0, 0);
        do_reset();
        seq031 = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
        for (int i = 0; i < 8; i++) begin
            cycle(4'b0011, 1'b1, 1'b0);
            check("r031_seq", 32'(grant), 32'(seq031[i]));
        end

        // All weights zero, everyone requesting: plain rotation with wrap.
        set_weights(0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(4'b1111, 1'b1, 1'b0);
            check("r032_enc", 32'(grantEnc), 32'(i % N));
        end

        // Holder 2 drops its request, then all requests vanish.
        do_reset();
        cycle(4'b0100, 1'b0, 1'b0);
        check("r033_hold2", 32'(grant), 32'h4);
        cycle(4'b0001, 1'b1, 1'b0);
        check("r033_to0", 32'(grant), 32'h1);
        cycle(4'b0000, 1'b1, 1'b0);
        check("r033_idle", 32'(grantValid), 32'h0);
        cycle(4'b0000, 1'b0, 1'b0);
        check("r020_idle", 32'(grant), 32'h0);

`ifdef ARB_LOCK_EN
        // Locked holder 3 keeps the grant across arbitration slots.
        do_reset();
        cycle(4'b1000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(4'b1001, 1'b1, 1'b1);
            check("r034_lock", 32'(grantEnc), 32'd3);
        end
        cycle(4'b1001, 1'b1, 1'b0);
        check("r034_release", 32'(grantEnc), 32'd0);
`endif

        // Asynchronous reset mid-grant, then reset priority on release.
        do_reset();
        cycle(4'b0100, 1'b0, 1'b0);
        check("r035_pre", 32'(grant), 32'h4);
        sysReset = 1'b0;
        model_reset();
        #1;
        check("r035_async_grant", 32'(grant), 32'h0);
        check("r035_async_valid", 32'(grantValid), 32'h0);
        @(posedge sysClk);
        #1;
        sysReset = 1'b1;
        cycle(4'b1100, 1'b0, 1'b0);
        check("r035_post", 32'(grant), 32'h4);

        // Randomized traffic, weights fixed per segment.
        for (int seg = 0; seg < 6; seg++) begin
            set_weights(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            do_reset();
            for (int c = 0; c < 300; c++) begin
                cycle(N'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
